// File: rtl/ysyx_exu_rs.sv
// ysyx_exu_rs: reservation station sitting between IQU dispatch and the ALU.
// Holds micro-ops until both operands are known, snoops the CDB for pending
// tags, and hands the lowest-index ready entry to the ALU each cycle.
module ysyx_exu_rs #(
   parameter int XLEN     = 32,
   parameter int RS_SIZE  = 4,
   parameter int ROB_SIZE = 8,
   parameter int TAG_W    = $clog2(ROB_SIZE) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_alu_op,
   input  logic [XLEN-1:0]  in_op1,
   input  logic [XLEN-1:0]  in_op2,
   input  logic [TAG_W-1:0] in_qj,
   input  logic [TAG_W-1:0] in_qk,
   input  logic [TAG_W-1:0] in_dest,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_dest,
   input  logic [XLEN-1:0]  cdb_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_alu_op,
   output logic [XLEN-1:0]  out_op1,
   output logic [XLEN-1:0]  out_op2,
   output logic [TAG_W-1:0] out_dest,
   output logic [XLEN-1:0]  out_pc
);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] r_busy;
   logic [4:0]         r_alu_op [RS_SIZE];
   logic [XLEN-1:0]    r_vj     [RS_SIZE];
   logic [XLEN-1:0]    r_vk     [RS_SIZE];
   logic [XLEN-1:0]    r_pc     [RS_SIZE];
   logic [TAG_W-1:0]   r_qj     [RS_SIZE];
   logic [TAG_W-1:0]   r_qk     [RS_SIZE];
   logic [TAG_W-1:0]   r_dest   [RS_SIZE];

   logic [RS_SIZE-1:0] w_rdy;
   logic [IDX_W-1:0]   w_free_idx;
   logic [IDX_W-1:0]   w_sel_idx;
   logic               w_alloc;
   logic               w_issue;
   logic               w_cdb_hit;

   // Tag 0 means "already ready", so a broadcast on tag 0 must never match.
   assign w_cdb_hit = cdb_valid && (cdb_dest != '0);

   // in_ready looks only at registered busy bits, so it never depends on in_valid
   // and a slot freed by this cycle's issue is reusable only next cycle.
   assign in_ready  = ~&r_busy;
   assign out_valid = |w_rdy;
   assign w_alloc   = in_valid && in_ready;
   assign w_issue   = out_valid && out_ready;

   // Lowest-index free entry receives the next dispatch.
   always_comb begin
      w_free_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--)
         if (!r_busy[i]) w_free_idx = IDX_W'(i);
   end

   // Lowest-index ready entry is offered to the ALU; defaults to entry 0 when idle.
   always_comb begin
      w_sel_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--)
         if (w_rdy[i]) w_sel_idx = IDX_W'(i);
   end

   assign out_alu_op = r_alu_op[w_sel_idx];
   assign out_op1    = r_vj[w_sel_idx];
   assign out_op2    = r_vk[w_sel_idx];
   assign out_dest   = r_dest[w_sel_idx];
   assign out_pc     = r_pc[w_sel_idx];

   for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
      // Ready only from registered state: a wakeup this edge issues next cycle.
      assign w_rdy[g] = r_busy[g] && (r_qj[g] == '0) && (r_qk[g] == '0);

      // Entry update: flush/reset clears, otherwise allocate (with CDB bypass)
      // or retire on issue and capture any matching broadcast.
      always_ff @(posedge clock) begin
         if (reset || flush) begin
            r_busy[g] <= 1'b0;
         end else if (w_alloc && (w_free_idx == IDX_W'(g))) begin
            r_busy[g]   <= 1'b1;
            r_alu_op[g] <= in_alu_op;
            r_dest[g]   <= in_dest;
            r_pc[g]     <= in_pc;
            if (w_cdb_hit && (in_qj == cdb_dest)) begin
               r_vj[g] <= cdb_result;
               r_qj[g] <= '0;
            end else begin
               r_vj[g] <= in_op1;
               r_qj[g] <= in_qj;
            end
            if (w_cdb_hit && (in_qk == cdb_dest)) begin
               r_vk[g] <= cdb_result;
               r_qk[g] <= '0;
            end else begin
               r_vk[g] <= in_op2;
               r_qk[g] <= in_qk;
            end
         end else begin
            if (w_issue && (w_sel_idx == IDX_W'(g)))
               r_busy[g] <= 1'b0;
            if (r_busy[g] && w_cdb_hit && (r_qj[g] == cdb_dest)) begin
               r_vj[g] <= cdb_result;
               r_qj[g] <= '0;
            end
            if (r_busy[g] && w_cdb_hit && (r_qk[g] == cdb_dest)) begin
               r_vk[g] <= cdb_result;
               r_qk[g] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_exu_rs.sv
// Bench for ysyx_exu_rs: directed scenarios followed by random traffic, all
// compared each cycle against a slot-list model of the station.
module tb_ysyx_exu_rs;
   localparam int XLEN = 32;
   localparam int RS   = 4;
   localparam int TW   = 4;

   logic            clock = 1'b0;
   logic            reset, flush, in_valid, in_ready;
   logic [4:0]      in_alu_op;
   logic [XLEN-1:0] in_op1, in_op2, in_pc;
   logic [TW-1:0]   in_qj, in_qk, in_dest;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_dest;
   logic [XLEN-1:0] cdb_result;
   logic            out_valid, out_ready;
   logic [4:0]      out_alu_op;
   logic [XLEN-1:0] out_op1, out_op2, out_pc;
   logic [TW-1:0]   out_dest;

   ysyx_exu_rs #(.XLEN(XLEN), .RS_SIZE(RS), .ROB_SIZE(8)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
      .in_op1(in_op1), .in_op2(in_op2), .in_qj(in_qj), .in_qk(in_qk),
      .in_dest(in_dest), .in_pc(in_pc),
      .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_result(cdb_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
      .out_op1(out_op1), .out_op2(out_op2), .out_dest(out_dest), .out_pc(out_pc)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit              busy;
      logic [4:0]      op;
      logic [XLEN-1:0] vj, vk, pc;
      logic [TW-1:0]   qj, qk, dest;
   } ent_t;

   ent_t m[RS];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_sel();
      for (int i = 0; i < RS; i++)
         if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) return i;
      return -1;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < RS; i++)
         if (!m[i].busy) return i;
      return -1;
   endfunction

   // One cycle: compare DUT to model mid-cycle, then advance the model across
   // the edge using the inputs held during that cycle.
   task automatic tick();
      int s, f;
      @(negedge clock);
      s = m_sel();
      f = m_free();
      chk("in_ready", 64'(in_ready), 64'(f >= 0));
      chk("out_valid", 64'(out_valid), 64'(s >= 0));
      if (s >= 0) begin
         chk("out_alu_op", 64'(out_alu_op), 64'(m[s].op));
         chk("out_op1", 64'(out_op1), 64'(m[s].vj));
         chk("out_op2", 64'(out_op2), 64'(m[s].vk));
         chk("out_dest", 64'(out_dest), 64'(m[s].dest));
         chk("out_pc", 64'(out_pc), 64'(m[s].pc));
      end
      if (reset || flush) begin
         for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      end else begin
         for (int i = 0; i < RS; i++) begin
            if (m[i].busy && cdb_valid && cdb_dest != 0) begin
               if (m[i].qj == cdb_dest) begin m[i].vj = cdb_result; m[i].qj = 0; end
               if (m[i].qk == cdb_dest) begin m[i].vk = cdb_result; m[i].qk = 0; end
            end
         end
         if (s >= 0 && out_ready) m[s].busy = 1'b0;
         if (in_valid && f >= 0) begin
            m[f].busy = 1'b1;
            m[f].op   = in_alu_op;
            m[f].pc   = in_pc;
            m[f].dest = in_dest;
            m[f].vj = in_op1; m[f].qj = in_qj;
            m[f].vk = in_op2; m[f].qk = in_qk;
            if (cdb_valid && cdb_dest != 0 && in_qj == cdb_dest) begin
               m[f].vj = cdb_result; m[f].qj = 0;
            end
            if (cdb_valid && cdb_dest != 0 && in_qk == cdb_dest) begin
               m[f].vk = cdb_result; m[f].qk = 0;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic disp(input logic [TW-1:0] qj, input logic [XLEN-1:0] op1,
                       input logic [TW-1:0] qk, input logic [XLEN-1:0] op2,
                       input logic [TW-1:0] dest);
      in_valid = 1'b1; in_qj = qj; in_op1 = op1; in_qk = qk; in_op2 = op2;
      in_dest = dest; in_pc = 32'h8000_0000 + 32'(dest) * 4; in_alu_op = 5'(dest);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alu_op = '0;
      in_op1 = '0; in_op2 = '0; in_qj = '0; in_qk = '0; in_dest = '0; in_pc = '0;
      cdb_valid = 1'b0; cdb_dest = '0; cdb_result = '0; out_ready = 1'b0;
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Ready dispatch issues the next cycle and is gone the cycle after.
      out_ready = 1'b1;
      disp(0, 5, 0, 7, 3);
      tick();
      in_valid = 1'b0;
      chk("rd_valid", 64'(out_valid), 64'd1);
      chk("rd_op1", 64'(out_op1), 64'd5);
      chk("rd_op2", 64'(out_op2), 64'd7);
      chk("rd_dest", 64'(out_dest), 64'd3);
      tick();
      chk("rd_gone", 64'(out_valid), 64'd0);

      // Wakeup: issue exactly one cycle after the broadcast.
      disp(2, 0, 0, 9, 1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("wk_wait", 64'(out_valid), 64'd0);
      cdb_valid = 1'b1; cdb_dest = 2; cdb_result = 32'h11;
      tick();
      cdb_valid = 1'b0;
      chk("wk_valid", 64'(out_valid), 64'd1);
      chk("wk_op1", 64'(out_op1), 64'h11);
      chk("wk_op2", 64'(out_op2), 64'd9);
      tick();

      // Same-cycle bypass of both operands from one broadcast.
      disp(4, 32'h55, 4, 32'h66, 5);
      cdb_valid = 1'b1; cdb_dest = 4; cdb_result = 32'hAB;
      tick();
      in_valid = 1'b0; cdb_valid = 1'b0;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_op1", 64'(out_op1), 64'hAB);
      chk("bp_op2", 64'(out_op2), 64'hAB);
      tick();

      // Fill the station, drop a fifth dispatch, then drain in order.
      out_ready = 1'b0;
      for (int d = 1; d <= 4; d++) begin
         disp(0, 32'(d), 0, 32'(d * 10), TW'(d));
         tick();
      end
      chk("full_in_ready", 64'(in_ready), 64'd0);
      disp(0, 99, 0, 99, 6);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("drain_d1", 64'(out_dest), 64'd1);
      tick();
      chk("drain_ready", 64'(in_ready), 64'd1);
      chk("drain_d2", 64'(out_dest), 64'd2);
      tick();
      chk("drain_d3", 64'(out_dest), 64'd3);
      tick();
      chk("drain_d4", 64'(out_dest), 64'd4);
      tick();
      chk("drain_empty", 64'(out_valid), 64'd0);

      // Flush beats same-cycle dispatch and capture; tag 5 later wakes nothing.
      out_ready = 1'b0;
      disp(0, 1, 0, 2, 1); tick();
      disp(0, 3, 0, 4, 2); tick();
      disp(5, 0, 0, 6, 3); tick();
      disp(0, 7, 0, 8, 4);
      flush = 1'b1; cdb_valid = 1'b1; cdb_dest = 5; cdb_result = 32'h77;
      tick();
      flush = 1'b0; in_valid = 1'b0; cdb_valid = 1'b0;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1; cdb_valid = 1'b1;
      tick();
      cdb_valid = 1'b0;
      chk("fl_no_issue", 64'(out_valid), 64'd0);

      // Reset with busy entries.
      out_ready = 1'b0;
      disp(0, 1, 0, 1, 1); tick();
      disp(3, 1, 0, 1, 2); tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      chk("rs_in_ready", 64'(in_ready), 64'd1);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_alu_op  = 5'($urandom);
         in_op1     = $urandom;
         in_op2     = $urandom;
         in_pc      = $urandom;
         in_qj      = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 8));
         in_qk      = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 8));
         in_dest    = TW'($urandom_range(1, 8));
         cdb_valid  = 1'($urandom_range(0, 1));
         cdb_dest   = TW'($urandom_range(0, 8));
         cdb_result = $urandom;
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 63) == 0);
         reset      = ($urandom_range(0, 127) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
